frame_read_requester: RTL and testbench

FRAME_READ_REQUESTER -- requirements
Module: frame_read_requester

---
 rtl/frame_read_requester.sv | 150 +++++++++++++++
 tb/tb_frame_read_requester.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_read_requester.sv
// Frame read requester: walks a frame buffer in the MIG address space one
// 128-bit phrase at a time, issuing read commands only while the return
// FIFO has room for every read in flight, and streams the returned phrases
// out with a start-of-frame tag.
module frame_read_requester #(
   parameter int FRAME_PHRASES = 9600,
   parameter int ADDR_WIDTH    = 27,
   parameter int ADDR_STRIDE   = 8,
   parameter int BASE_ADDR     = 0,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  enable_in,
   output logic                  app_en,
   input  logic                  app_rdy,
   output logic [2:0]            app_cmd,
   output logic [ADDR_WIDTH-1:0] app_addr,
   input  logic [127:0]          app_rd_data,
   input  logic                  app_rd_data_valid,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic [127:0]          data_out,
   output logic                  tuser_out,
   output logic                  error_out
);

   localparam int IW = (FRAME_PHRASES > 1) ? $clog2(FRAME_PHRASES) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;

   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_PHRASES - 1);

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] req_idx_q, req_idx_d;
   logic [IW-1:0] ret_idx_q, ret_idx_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] occupancy_q, occupancy_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          error_q, error_d;

   // Bit 128 holds the start-of-frame tag, bits 127:0 the phrase.
   logic [128:0]  fifo_mem [FIFO_DEPTH];

   logic          accept;
   logic          fifo_full;
   logic          ret_ok;
   logic          pop;
   logic [CW-1:0] credit_q, credit_d;

   assign accept    = (state_q == S_ISSUE) && app_rdy;
   assign fifo_full = (occupancy_q == DEPTH_C);
   // Returns are only legal against a read we issued and have room for.
   assign ret_ok    = app_rd_data_valid && (outstanding_q != '0) && !fifo_full;
   assign pop       = valid_out && ready_out;
   // Credit counts both buffered phrases and reads still in flight, so every
   // accepted read is guaranteed a FIFO slot when it returns.
   assign credit_q  = DEPTH_C - occupancy_q - outstanding_q;
   assign credit_d  = DEPTH_C - occupancy_d - outstanding_d;

   assign app_en    = (state_q == S_ISSUE);
   assign app_cmd   = 3'b001;
   assign app_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(req_idx_q) * ADDR_WIDTH'(ADDR_STRIDE);

   assign valid_out = (occupancy_q != '0);
   assign data_out  = valid_out ? fifo_mem[rd_ptr_q][127:0] : '0;
   assign tuser_out = valid_out & fifo_mem[rd_ptr_q][128];
   assign error_out = error_q;

   // Next-state for counters, pointers, error flag and the issue FSM.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      state_d       = state_q;
      req_idx_d     = req_idx_q;
      ret_idx_d     = ret_idx_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      error_d       = error_q | (app_rd_data_valid && !ret_ok);
      outstanding_d = outstanding_q + CW'(accept) - CW'(ret_ok);
      occupancy_d   = occupancy_q + CW'(ret_ok) - CW'(pop);

      if (accept) begin
         req_idx_d = (req_idx_q == LAST_IDX) ? '0 : req_idx_q + 1'b1;
      end
      if (ret_ok) begin
         ret_idx_d = (ret_idx_q == LAST_IDX) ? '0 : ret_idx_q + 1'b1;
         wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (enable_in) state_d = (credit_q != '0) ? S_ISSUE : S_STALL;
         end
         S_ISSUE: begin
            // A presented command is held until accepted, whatever enable_in does.
            if (accept) begin
               if (!enable_in)          state_d = S_IDLE;
               else if (credit_d == '0) state_d = S_STALL;
            end
         end
         S_STALL: begin
            if (!enable_in)          state_d = S_IDLE;
            else if (credit_q != '0) state_d = S_ISSUE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_in) begin
         state_q       <= S_IDLE;
         req_idx_q     <= '0;
         ret_idx_q     <= '0;
         outstanding_q <= '0;
         occupancy_q   <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_idx_q     <= req_idx_d;
         ret_idx_q     <= ret_idx_d;
         outstanding_q <= outstanding_d;
         occupancy_q   <= occupancy_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         error_q       <= error_d;
      end
   end

   // Return FIFO storage: write each accepted return with its frame-start tag.
   always_ff @(posedge clk_in) begin
      // NOTE: storage is not reset; occupancy gates the outputs, so stale entries are never visible.
      if (ret_ok) begin
         fifo_mem[wr_ptr_q] <= {(ret_idx_q == '0), app_rd_data};
      end
   end

endmodule

// File: tb/tb_frame_read_requester.sv
// Directed bench for frame_read_requester: a default instance plus a
// FRAME_PHRASES=4 instance share all inputs; a small MIG model returns data
// (the read address) a few cycles after each accept.
module tb_frame_read_requester;

   logic         clk_in = 1'b0;
   logic         rst_in;
   logic         enable_in;
   logic         app_rdy;
   logic [127:0] app_rd_data;
   logic         app_rd_data_valid;
   logic         ready_out;

   logic         app_en, w_app_en;
   logic [2:0]   app_cmd, w_app_cmd;
   logic [26:0]  app_addr, w_app_addr;
   logic         valid_out, w_valid_out;
   logic [127:0] data_out, w_data_out;
   logic         tuser_out, w_tuser_out;
   logic         error_out, w_error_out;

   logic         mig_on;
   logic         man_valid;
   logic [127:0] man_data;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int pop_cnt = 0;

   always #5 clk_in = ~clk_in;

   frame_read_requester u_dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
      .app_en(app_en), .app_rdy(app_rdy), .app_cmd(app_cmd), .app_addr(app_addr),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
      .tuser_out(tuser_out), .error_out(error_out)
   );

   frame_read_requester #(.FRAME_PHRASES(4)) u_wrap (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
      .app_en(w_app_en), .app_rdy(app_rdy), .app_cmd(w_app_cmd), .app_addr(w_app_addr),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .valid_out(w_valid_out), .ready_out(ready_out), .data_out(w_data_out),
      .tuser_out(w_tuser_out), .error_out(w_error_out)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // MIG model: returns the accepted address as data three cycles later,
   // or replays the manual pulse when the model is switched off.
   initial begin
      logic        pv [4];
      logic [26:0] pa [4];
      for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pa[i] = '0; end
      app_rd_data_valid = 1'b0;
      app_rd_data       = '0;
      forever begin
         @(negedge clk_in);
         #1;
         if (rst_in || !mig_on) begin
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
         end else begin
            for (int i = 3; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
            pv[0] = app_en && app_rdy;
            pa[0] = app_addr;
         end
         if (mig_on) begin
            app_rd_data_valid = pv[3];
            app_rd_data       = 128'(pa[3]);
         end else begin
            app_rd_data_valid = man_valid;
            app_rd_data       = man_data;
         end
      end
   end

   task automatic tick();
      @(negedge clk_in);
   endtask

   // Observe the upcoming edge with current inputs, then step past it.
   task automatic run_cycles(input int n);
      repeat (n) begin
         if (app_en && app_rdy) begin
            check("addr", 128'(app_addr), 128'(acc_cnt * 8));
            check("wrap_addr", 128'(w_app_addr), 128'((acc_cnt % 4) * 8));
            acc_cnt++;
         end
         if (valid_out && ready_out) begin
            check("data", data_out, 128'(pop_cnt * 8));
            check("tuser", 128'(tuser_out), 128'(pop_cnt == 0));
            check("wrap_tuser", 128'(w_tuser_out), 128'((pop_cnt % 4) == 0));
            pop_cnt++;
         end
         @(negedge clk_in);
      end
   endtask

   task automatic do_reset();
      rst_in = 1'b1; enable_in = 1'b0; app_rdy = 1'b0; ready_out = 1'b0;
      mig_on = 1'b0; man_valid = 1'b0; man_data = '0;
      tick(); tick();
      rst_in = 1'b0;
      acc_cnt = 0;
      pop_cnt = 0;
   endtask

   initial begin
      rst_in = 1'b1; enable_in = 1'b0; app_rdy = 1'b0; ready_out = 1'b0;
      mig_on = 1'b0; man_valid = 1'b0; man_data = '0;

      // Reset values.
      tick(); tick(); tick();
      check("rst_app_en", 128'(app_en), 128'(0));
      check("rst_app_addr", 128'(app_addr), 128'(0));
      check("rst_app_cmd", 128'(app_cmd), 128'(3'b001));
      check("rst_valid", 128'(valid_out), 128'(0));
      check("rst_tuser", 128'(tuser_out), 128'(0));
      check("rst_data", data_out, 128'(0));
      check("rst_error", 128'(error_out), 128'(0));
      rst_in = 1'b0;
      tick();

      // Unexpected return data sets a sticky error and buffers nothing.
      man_valid = 1'b1; man_data = 128'hDEAD;
      tick();
      man_valid = 1'b0;
      check("err_set", 128'(error_out), 128'(1));
      check("err_valid", 128'(valid_out), 128'(0));
      tick(); tick(); tick();
      check("err_sticky", 128'(error_out), 128'(1));
      check("err_valid_hold", 128'(valid_out), 128'(0));
      check("err_wrap", 128'(w_error_out), 128'(1));
      do_reset();
      check("err_cleared", 128'(error_out), 128'(0));

      // Streaming: addresses step by 8, wrap instance wraps after 4 phrases.
      mig_on = 1'b1; enable_in = 1'b1; app_rdy = 1'b1; ready_out = 1'b1;
      run_cycles(1);
      for (int i = 0; i < 20; i++) begin
         check("no_stall", 128'(app_en), 128'(1));
         run_cycles(1);
      end
      enable_in = 1'b0;
      run_cycles(1);
      check("stream_idle", 128'(app_en), 128'(0));
      check("stream_acc", 128'(acc_cnt), 128'(21));
      run_cycles(12);
      check("stream_pops", 128'(pop_cnt), 128'(21));
      check("stream_empty", 128'(valid_out), 128'(0));
      check("stream_err", 128'(error_out), 128'(0));

      // Credit stall: no pops, so exactly FIFO_DEPTH reads are issued.
      do_reset();
      mig_on = 1'b1; enable_in = 1'b1; app_rdy = 1'b1; ready_out = 1'b0;
      run_cycles(30);
      check("stall_acc", 128'(acc_cnt), 128'(16));
      check("stall_app_en", 128'(app_en), 128'(0));
      check("stall_state", 128'(u_dut.state_q), 128'(2));
      check("stall_valid", 128'(valid_out), 128'(1));
      check("stall_head", data_out, 128'(0));
      check("stall_tuser", 128'(tuser_out), 128'(1));
      ready_out = 1'b1;
      run_cycles(1);
      ready_out = 1'b0;
      run_cycles(12);
      check("stall_one_more", 128'(acc_cnt), 128'(17));
      check("stall_app_en2", 128'(app_en), 128'(0));
      check("stall_head2", data_out, 128'(8));
      check("stall_err", 128'(error_out), 128'(0));

      // app_rdy backpressure: command held while enable_in toggles.
      do_reset();
      mig_on = 1'b1; enable_in = 1'b1; app_rdy = 1'b0; ready_out = 1'b0;
      tick();
      check("bp_app_en", 128'(app_en), 128'(1));
      check("bp_addr", 128'(app_addr), 128'(0));
      for (int i = 0; i < 5; i++) begin
         enable_in = i[0];
         tick();
         check("bp_hold_en", 128'(app_en), 128'(1));
         check("bp_hold_addr", 128'(app_addr), 128'(0));
      end
      enable_in = 1'b0; app_rdy = 1'b1;
      tick();
      app_rdy = 1'b0;
      check("bp_idle_en", 128'(app_en), 128'(0));
      check("bp_idle_state", 128'(u_dut.state_q), 128'(0));
      check("bp_next_addr", 128'(app_addr), 128'(8));
      repeat (6) tick();
      check("bp_valid", 128'(valid_out), 128'(1));
      check("bp_data", data_out, 128'(0));
      check("bp_tuser", 128'(tuser_out), 128'(1));
      tick(); tick();
      check("bp_data_stable", data_out, 128'(0));
      check("bp_tuser_stable", 128'(tuser_out), 128'(1));

      // Mid-stream reset with 3 outstanding and 5 buffered.
      do_reset();
      enable_in = 1'b1; app_rdy = 1'b1; ready_out = 1'b0;
      run_cycles(1);
      run_cycles(7);
      enable_in = 1'b0;
      run_cycles(1);
      app_rdy = 1'b0;
      check("mid_acc", 128'(acc_cnt), 128'(8));
      check("mid_idle", 128'(app_en), 128'(0));
      for (int i = 0; i < 5; i++) begin
         man_valid = 1'b1; man_data = 128'(32'h1000 + i);
         tick();
      end
      man_valid = 1'b0;
      tick();
      check("mid_valid", 128'(valid_out), 128'(1));
      check("mid_head", data_out, 128'(32'h1000));
      check("mid_outstanding", 128'(u_dut.outstanding_q), 128'(3));
      check("mid_occupancy", 128'(u_dut.occupancy_q), 128'(5));
      rst_in = 1'b1;
      tick();
      check("mid_rst_app_en", 128'(app_en), 128'(0));
      check("mid_rst_addr", 128'(app_addr), 128'(0));
      check("mid_rst_valid", 128'(valid_out), 128'(0));
      check("mid_rst_data", data_out, 128'(0));
      check("mid_rst_tuser", 128'(tuser_out), 128'(0));
      check("mid_rst_error", 128'(error_out), 128'(0));
      check("mid_rst_cmd", 128'(app_cmd), 128'(3'b001));
      rst_in = 1'b0;
      tick();
      man_valid = 1'b1; man_data = 128'hBEEF;
      tick();
      man_valid = 1'b0;
      check("late_return_err", 128'(error_out), 128'(1));
      check("late_return_valid", 128'(valid_out), 128'(0));
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
